// File: rtl/lc3b_types.sv
// Shared LC-3b type package: cache-line data and line-address types, plus a byte-lane merge helper.
package lc3b_types;

    typedef logic [127:0] lc3b_line;
    typedef logic [11:0]  lc3b_line_addr;

    localparam int LC3B_LINE_BYTES = 16;

    // Replace only the bytes of old_line whose lane bit is set.
    function automatic lc3b_line merge_lanes(input lc3b_line old_line,
                                             input lc3b_line new_line,
                                             input logic [LC3B_LINE_BYTES-1:0] lanes);
        lc3b_line merged;
        merged = old_line;
        for (int i = 0; i < LC3B_LINE_BYTES; i++) begin
            if (lanes[i]) merged[8*i +: 8] = new_line[8*i +: 8];
            else          merged[8*i +: 8] = old_line[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/wb_line_array.sv
// Line storage for wb_line_slave: DEPTH_LINES x 128 bits, one byte-lane-enabled write port,
// combinational read. Contents are intentionally not reset.
module wb_line_array
    import lc3b_types::*;
#(
    parameter int DEPTH_LINES = 256,
    localparam int IW = $clog2(DEPTH_LINES)
) (
    input  logic                       clk,
    input  logic [IW-1:0]              wr_idx,
    input  logic [LC3B_LINE_BYTES-1:0] wr_be,
    input  lc3b_line                   wr_data,
    input  logic [IW-1:0]              rd_idx,
    output lc3b_line                   rd_data
);

    lc3b_line mem [DEPTH_LINES];

    // Byte-lane write; untouched lanes keep their old contents
    always_ff @(posedge clk) begin
        if (|wr_be) mem[wr_idx] <= merge_lanes(mem[wr_idx], wr_data, wr_be);
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/wb_line_slave.sv
// Wishbone 128-bit line slave with fixed access latency and byte-lane writes.
// Optional WB_LINE_SLAVE_LAST_LINE_EN adds a one-entry last-read buffer giving 1-cycle read hits.
module wb_line_slave
    import lc3b_types::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_cyc,
    input  logic          wb_stb,
    input  logic          wb_we,
    input  lc3b_line_addr wb_adr,
    input  logic [15:0]   wb_sel,
    input  lc3b_line      wb_dat_m,
    output lc3b_line      wb_dat_s,
    output logic          wb_ack
);

    localparam int IW = $clog2(DEPTH_LINES);
    localparam int CW = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [1:0]    state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          load_req_s;
    lc3b_line_addr adr_r;
    logic          we_r;
    logic [15:0]   sel_r;
    lc3b_line      dat_r;
    lc3b_line      dat_s_r;
    logic          ack_r;

    logic          req_s;
    logic          hit_s;
    lc3b_line_addr adr_eff_s;
    logic          we_eff_s;
    logic          enter_ack_s;
    logic          rd_load_s;
    lc3b_line      arr_rd_s;
    lc3b_line      rd_line_s;
    logic [15:0]   wr_be_s;

    assign req_s = wb_cyc & wb_stb;

    // In IDLE the request is not latched yet, so the live bus fields describe it.
    assign adr_eff_s   = (state_r == ST_IDLE) ? wb_adr : adr_r;
    assign we_eff_s    = (state_r == ST_IDLE) ? wb_we  : we_r;
    assign enter_ack_s = (state_s == ST_ACK) && (state_r != ST_ACK);
    assign rd_load_s   = enter_ack_s & ~we_eff_s;
    assign wr_be_s     = ((state_r == ST_ACK) && we_r) ? sel_r : 16'd0;

    wb_line_array #(
        .DEPTH_LINES (DEPTH_LINES)
    ) u_array (
        .clk     (clk),
        .wr_idx  (adr_r[IW-1:0]),
        .wr_be   (wr_be_s),
        .wr_data (dat_r),
        .rd_idx  (adr_eff_s[IW-1:0]),
        .rd_data (arr_rd_s)
    );

`ifdef WB_LINE_SLAVE_LAST_LINE_EN
    logic          buf_valid_r;
    lc3b_line_addr buf_tag_r;
    lc3b_line      buf_line_r;

    assign hit_s     = buf_valid_r & ~wb_we & (wb_adr == buf_tag_r);
    assign rd_line_s = ((state_r == ST_IDLE) && hit_s) ? buf_line_r : arr_rd_s;

    // Last-read buffer: refilled on every read ACK, dropped by a write to the same index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_r <= 1'b0;
            buf_tag_r   <= 12'd0;
            buf_line_r  <= 128'd0;
        end else if (rd_load_s) begin
            buf_valid_r <= 1'b1;
            buf_tag_r   <= adr_eff_s;
            buf_line_r  <= rd_line_s;
        end else if ((state_r == ST_ACK) && we_r && (adr_r[IW-1:0] == buf_tag_r[IW-1:0])) begin
            buf_valid_r <= 1'b0;
        end
    end
`else
    logic unused_s;

    assign hit_s     = 1'b0;
    assign rd_line_s = arr_rd_s;
    assign unused_s  = ^adr_eff_s;
`endif

    // Next-state and latency counter decode
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        load_req_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    load_req_s = 1'b1;
                    if ((LATENCY == 1) || hit_s) begin
                        state_s = ST_ACK;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = CNT_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Abort wins over the final countdown step.
                if (!req_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_ONE) begin
                    state_s = ST_ACK;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // FSM, request latch, registered ACK and read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            adr_r   <= 12'd0;
            we_r    <= 1'b0;
            sel_r   <= 16'd0;
            dat_r   <= 128'd0;
            dat_s_r <= 128'd0;
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ack_r   <= (state_s == ST_ACK);
            if (load_req_s) begin
                adr_r <= wb_adr;
                we_r  <= wb_we;
                sel_r <= wb_sel;
                dat_r <= wb_dat_m;
            end
            if (rd_load_s) dat_s_r <= rd_line_s;
        end
    end

    assign wb_ack   = ack_r;
    assign wb_dat_s = dat_s_r;

endmodule
